ysyx_22050039_lsu: RTL and testbench
====================================

Name: ysyx_22050039_lsu

Overview:
Multi-cycle load/store unit sitting directly downstream of the execute stage and upstream of writeback. It takes the execute result (effective address or ALU value) plus store data and a memory-op descriptor. It performs at most one aligned 64-bit-bus memory transaction, then hands the final writeback value, or a misalignment fault, to writeback over a valid/ready handshake.

Parameters:
XLEN, 64, datapath width; only 64 is supported (8-byte bus, byte lanes addr[2:0]).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
in_valid  in  1  execute stage presents an op
in_ready  out  1  LSU accepts the op this cycle
in_op  in  2  NONE=0, LOAD=1, STORE=2 (3 reserved, treated as NONE)
in_size  in  3  funct3: 0 b, 1 h, 2 w, 3 d, 4 bu, 5 hu, 6 wu (7 reserved → fault)
in_result  in  XLEN  execute result: address for LOAD/STORE, passthrough value for NONE
in_wdata  in  XLEN  store data (rs2)
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts the request
mem_addr  out  XLEN  address with bits [2:0] zeroed
mem_wen  out  1  1 = write
mem_wdata  out  XLEN  store data shifted to its lane
mem_wmask  out  XLEN/8  byte enables; all zero for reads
mem_rsp_valid  in  1  read data valid or write acknowledge
mem_rdata  in  XLEN  full 8-byte read word
out_valid  out  1  result ready for writeback
out_ready  in  1  writeback consumes the result
out_data  out  XLEN  writeback value (loaded data, in_result for NONE, 0 for STORE)
out_fault  out  1  misaligned access or reserved size; qualified by out_valid

Behaviour:
- Reset (rst==0 at posedge): state IDLE. in_ready=1. mem_req_valid, mem_wen, mem_wmask, out_valid, out_fault all 0. mem_addr, mem_wdata, out_data are 0.
- States: IDLE, REQ, WAIT_RSP, DONE. in_ready = (state==IDLE).
- IDLE, in_valid=1: latch op, size, in_result, in_wdata.
  - NONE → DONE, out_data=in_result.
  - Misaligned or reserved size → DONE with out_fault=1, out_data=0, no bus request.
  - Otherwise → REQ.
  - Misaligned means h/hu with addr[0]≠0; w/wu with addr[1:0]≠0; d with addr[2:0]≠0.
- REQ: mem_req_valid=1, with mem_addr, mem_wen, mem_wdata and mem_wmask held stable until mem_req_ready=1. On handshake → WAIT_RSP.
  - Store mask: b 0x01<<a, h 0x03<<a, w 0x0F<<a, d 0xFF, where a=addr[2:0].
  - Store data is shifted left by 8*a.
- WAIT_RSP: mem_req_valid=0.
  - mem_rsp_valid is sampled only in this state. A response in the same cycle as the REQ handshake is not permitted.
  - On mem_rsp_valid → DONE. A load registers the extracted lane: shift right by 8*a, then sign-extend for b/h/w or zero-extend for bu/hu/wu/d. A store registers out_data=0.
  - No timeout; the unit waits indefinitely.
- DONE: out_valid=1, with out_data and out_fault held stable until out_ready=1, then → IDLE. No new op is accepted in DONE; max throughput is one op per 2 cycles.
- Latency, from acceptance edge N to out_valid:
  - NONE/fault: N+1.
  - Memory op with mem_req_ready=1 at N+1 and mem_rsp_valid at N+2: out_valid at N+3.
- Reset mid-operation has priority over everything: the state returns to IDLE, and mem_req_valid and out_valid drop the next cycle. An orphaned mem_rsp_valid arriving in IDLE/REQ is ignored.
- in_valid while in_ready=0 is ignored; the upstream must hold it.

Decomposition:
- Shared package ysyx_22050039_pkg:
  - lsu_op enum (NONE/LOAD/STORE).
  - funct3 size constants (SZ_B..SZ_WU).
  - lsu_state enum.
  - BUS_BYTES = XLEN/8.
- One combinational sub-module, ysyx_22050039_lsu_align, with two functions:
  - Store direction: (size, a, wdata) → (wmask, shifted wdata).
  - Load direction: (size, a, rdata) → extended load value.
  - It also outputs the misaligned flag.
- The FSM, registers and handshakes stay in the top module.

Test Plan:
- NONE op, in_result=0x1234 → out_valid one cycle after acceptance, out_data=0x1234, out_fault=0, mem_req_valid never asserts.
- LOAD lb, addr=0x80000003, mem_rdata=0x0000_0000_8000_0000 → mem_addr=0x80000000, mem_wmask=0. Lane 3 is 0x80, so out_data=0xFFFF_FFFF_FFFF_FF80. The same op with lbu gives out_data=0x80.
- STORE sh, addr=0x80000006, wdata=0xABCD, mem_req_ready held 0 for 3 cycles → request fields stay stable throughout, mem_wmask=0xC0, mem_wdata=0xABCD_0000_0000_0000. After the ack, out_valid=1 and out_data=0.
- LOAD lw, addr=0x80000002 → out_fault=1 one cycle after acceptance, no bus request. in_size=7 also faults.
- Backpressure and reset: hold out_ready=0 for 4 cycles in DONE → out_data stable and in_ready=0. Then pull rst=0 during WAIT_RSP of a load and send mem_rsp_valid afterwards → next cycle IDLE, out_valid=0, the response is ignored, and a following NONE op completes normally.

Source files
------------

// File: rtl/ysyx_22050039_pkg.sv
// Shared types and constants for the load/store unit.
package ysyx_22050039_pkg;

    localparam int XLEN      = 64;
    localparam int BUS_BYTES = XLEN / 8;

    // Memory-op descriptor from execute; encoding 3 decodes to OP_NONE.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } lsu_op_e;

    // funct3 access sizes; 3'd7 is reserved and faults.
    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_D  = 3'd3;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;
    localparam logic [2:0] SZ_WU = 3'd6;
    localparam logic [2:0] SZ_RSV = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/ysyx_22050039_lsu_align.sv
// Byte-lane alignment: store mask/data placement, load extraction and
// extension, and the misalignment check. Purely combinational.
module ysyx_22050039_lsu_align
    import ysyx_22050039_pkg::*;
(
    input  logic [2:0]           size,
    input  logic [2:0]           a,
    input  logic [XLEN-1:0]      wdata,
    input  logic [XLEN-1:0]      rdata,
    output logic [BUS_BYTES-1:0] wmask,
    output logic [XLEN-1:0]      wdata_sh,
    output logic [XLEN-1:0]      ldata,
    output logic                 misaligned
);

    // Store direction: returns {byte mask, lane-shifted data}.
    function automatic logic [BUS_BYTES+XLEN-1:0] store_align(
        input logic [2:0]      sz,
        input logic [2:0]      off,
        input logic [XLEN-1:0] d
    );
        logic [BUS_BYTES-1:0] m;
        logic [XLEN-1:0]      sd;
        case (sz)
            SZ_B, SZ_BU: m = 8'h01;
            SZ_H, SZ_HU: m = 8'h03;
            SZ_W, SZ_WU: m = 8'h0F;
            default:     m = 8'hFF;
        endcase
        m  = m << off;
        sd = d << {off, 3'b000};
        return {m, sd};
    endfunction

    // Load direction: bring the addressed lane down to bit 0 and extend.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      sz,
        input logic [2:0]      off,
        input logic [XLEN-1:0] d
    );
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = d >> {off, 3'b000};
        case (sz)
            SZ_B:    r = {{56{sh[7]}},  sh[7:0]};
            SZ_H:    r = {{48{sh[15]}}, sh[15:0]};
            SZ_W:    r = {{32{sh[31]}}, sh[31:0]};
            SZ_BU:   r = {56'd0, sh[7:0]};
            SZ_HU:   r = {48'd0, sh[15:0]};
            SZ_WU:   r = {32'd0, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    // Misalignment and lane computations.
    always_comb begin
        {wmask, wdata_sh} = store_align(size, a, wdata);
        ldata             = load_extract(size, a, rdata);
        case (size)
            SZ_H, SZ_HU: misaligned = a[0];
            SZ_W, SZ_WU: misaligned = |a[1:0];
            SZ_D:        misaligned = |a;
            default:     misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050039_lsu.sv
// Multi-cycle load/store unit: one aligned bus transaction per op, result
// handed to writeback over valid/ready.
module ysyx_22050039_lsu
    import ysyx_22050039_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [2:0]           in_size,
    input  logic [XLEN-1:0]      in_result,
    input  logic [XLEN-1:0]      in_wdata,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [XLEN-1:0]      mem_addr,
    output logic                 mem_wen,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [BUS_BYTES-1:0] mem_wmask,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_data,
    output logic                 out_fault
);

    lsu_state_e           state, state_nxt;
    lsu_op_e              op_q, op_dec;
    logic [2:0]           size_q;
    logic [XLEN-1:0]      addr_q;
    logic [XLEN-1:0]      wdata_q;
    logic [XLEN-1:0]      out_data_q;
    logic                 out_fault_q;

    logic [2:0]           al_size;
    logic [2:0]           al_a;
    logic [BUS_BYTES-1:0] al_wmask;
    logic [XLEN-1:0]      al_wdata;
    logic [XLEN-1:0]      al_ldata;
    logic                 al_mis;
    logic                 acc_fault;

    // In IDLE the aligner judges the incoming op; afterwards the latched one.
    assign al_size = (state == S_IDLE) ? in_size        : size_q;
    assign al_a    = (state == S_IDLE) ? in_result[2:0] : addr_q[2:0];

    ysyx_22050039_lsu_align u_align (
        .size       (al_size),
        .a          (al_a),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .wmask      (al_wmask),
        .wdata_sh   (al_wdata),
        .ldata      (al_ldata),
        .misaligned (al_mis)
    );

    // Decode the op; reserved encoding behaves as NONE.
    always_comb begin
        case (in_op)
            2'd1:    op_dec = OP_LOAD;
            2'd2:    op_dec = OP_STORE;
            default: op_dec = OP_NONE;
        endcase
        acc_fault = (in_size == SZ_RSV) || al_mis;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (op_dec == OP_NONE || acc_fault) state_nxt = S_DONE;
                    else                                state_nxt = S_REQ;
                end
            end
            S_REQ:      if (mem_req_ready) state_nxt = S_WAIT_RSP;
            S_WAIT_RSP: if (mem_rsp_valid) state_nxt = S_DONE;
            S_DONE:     if (out_ready)     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Op latch and result register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q        <= OP_NONE;
            size_q      <= SZ_B;
            addr_q      <= '0;
            wdata_q     <= '0;
            out_data_q  <= '0;
            out_fault_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= op_dec;
                        size_q  <= in_size;
                        addr_q  <= in_result;
                        wdata_q <= in_wdata;
                        if (op_dec == OP_NONE) begin
                            out_data_q  <= in_result;
                            out_fault_q <= 1'b0;
                        end else begin
                            out_data_q  <= '0;
                            out_fault_q <= acc_fault;
                        end
                    end
                end
                S_WAIT_RSP: begin
                    if (mem_rsp_valid)
                        out_data_q <= (op_q == OP_LOAD) ? al_ldata : '0;
                end
                default: ;
            endcase
        end
    end

    // Bus and writeback outputs; request fields come straight from latches.
    always_comb begin
        in_ready      = (state == S_IDLE);
        mem_req_valid = (state == S_REQ);
        mem_addr      = {addr_q[XLEN-1:3], 3'b000};
        mem_wen       = (state == S_REQ) && (op_q == OP_STORE);
        mem_wmask     = mem_wen ? al_wmask : '0;
        mem_wdata     = al_wdata;
        out_valid     = (state == S_DONE);
        out_data      = out_data_q;
        out_fault     = out_fault_q;
    end

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Scoreboard bench for the load/store unit.
module tb_ysyx_22050039_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_size;
    logic [63:0] in_result;
    logic [63:0] in_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_fault;

    typedef struct {
        logic [63:0] data;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   req_cnt = 0;

    always #5 clk = ~clk;

    ysyx_22050039_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
        .in_result(in_result), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_fault(out_fault)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Retire completed results against the scoreboard; count bus requests.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_req_valid === 1'b1) req_cnt++;
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_fault", {63'd0, out_fault}, {63'd0, e.fault});
            end
        end
    end

    // Present one op at a negedge and return just after its acceptance edge.
    task automatic send(input logic [1:0] op, input logic [2:0] sz,
                        input logic [63:0] res, input logic [63:0] wd);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 64'd0, 64'd1);
        in_valid  = 1'b1;
        in_op     = op;
        in_size   = sz;
        in_result = res;
        in_wdata  = wd;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic push(input logic [63:0] d, input logic f);
        exp_t e;
        e.data  = d;
        e.fault = f;
        sb.push_back(e);
    endtask

    // Serve one bus transaction: stall, handshake, then respond one cycle later.
    task automatic mem_txn(input logic [63:0] ea, input logic ew, input logic [7:0] em,
                           input logic [63:0] ed, input logic [63:0] rd, input int stall);
        for (int i = 0; i <= stall; i++) begin
            mem_req_ready = (i == stall);
            @(negedge clk);
            chk("req_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wen", {63'd0, mem_wen}, {63'd0, ew});
            chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, em});
            if (ew) chk("mem_wdata", mem_wdata, ed);
            @(posedge clk);
            #1;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd;
        @(negedge clk);
        chk("req_drop", {63'd0, mem_req_valid}, 64'd0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 64'h0;
        @(negedge clk);
        chk("mem_lat", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        int r0;
        rst = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_size = 3'd0;
        in_result = '0; in_wdata = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rdata = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_wen", {63'd0, mem_wen}, 64'd0);
        chk("rst_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_fault", {63'd0, out_fault}, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        rst = 1'b1;

        // NONE passthrough, one-cycle latency, no bus traffic.
        r0 = req_cnt;
        push(64'h1234, 1'b0);
        send(2'd0, 3'd0, 64'h1234, 64'h0);
        @(negedge clk);
        chk("none_lat", {63'd0, out_valid}, 64'd1);
        drain();
        chk("none_noreq", req_cnt, r0);

        // Reserved op encoding behaves as NONE.
        push(64'hDEAD_BEEF, 1'b0);
        send(2'd3, 3'd3, 64'hDEAD_BEEF, 64'h0);
        drain();

        // lb / lbu of lane 3.
        push(64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        send(2'd1, 3'd0, 64'h8000_0003, 64'h0);
        mem_txn(64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_8000_0000, 0);
        drain();
        push(64'h80, 1'b0);
        send(2'd1, 3'd4, 64'h8000_0003, 64'h0);
        mem_txn(64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_8000_0000, 0);
        drain();

        // lw upper word (sign), lhu lane 2, ld aligned.
        push(64'hFFFF_FFFF_8765_4321, 1'b0);
        send(2'd1, 3'd2, 64'h8000_0014, 64'h0);
        mem_txn(64'h8000_0010, 1'b0, 8'h00, 64'h0, 64'h8765_4321_0000_0000, 1);
        drain();
        push(64'h0000_0000_0000_F00D, 1'b0);
        send(2'd1, 3'd5, 64'h8000_0002, 64'h0);
        mem_txn(64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_F00D_1111, 0);
        drain();
        push(64'hCAFE_BABE_0123_4567, 1'b0);
        send(2'd1, 3'd3, 64'h8000_0008, 64'h0);
        mem_txn(64'h8000_0008, 1'b0, 8'h00, 64'h0, 64'hCAFE_BABE_0123_4567, 0);
        drain();

        // sh with 3 stall cycles; sw and sb at other lanes.
        push(64'h0, 1'b0);
        send(2'd2, 3'd1, 64'h8000_0006, 64'hABCD);
        mem_txn(64'h8000_0000, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 3);
        drain();
        push(64'h0, 1'b0);
        send(2'd2, 3'd2, 64'h8000_0004, 64'h1111_2222_3333_4444);
        mem_txn(64'h8000_0000, 1'b1, 8'hF0, 64'h3333_4444_0000_0000, 64'h0, 0);
        drain();
        push(64'h0, 1'b0);
        send(2'd2, 3'd0, 64'h8000_0001, 64'h5A);
        mem_txn(64'h8000_0000, 1'b1, 8'h02, 64'h0000_0000_0000_5A00, 64'h0, 0);
        drain();

        // Faults: misaligned lw, misaligned sd, reserved size.
        r0 = req_cnt;
        push(64'h0, 1'b1);
        send(2'd1, 3'd2, 64'h8000_0002, 64'h0);
        @(negedge clk);
        chk("fault_lat", {63'd0, out_valid}, 64'd1);
        drain();
        push(64'h0, 1'b1);
        send(2'd2, 3'd3, 64'h8000_0004, 64'h0);
        drain();
        push(64'h0, 1'b1);
        send(2'd1, 3'd7, 64'h8000_0000, 64'h0);
        drain();
        chk("fault_noreq", req_cnt, r0);

        // Writeback backpressure in DONE.
        out_ready = 1'b0;
        push(64'h55AA, 1'b0);
        send(2'd0, 3'd0, 64'h55AA, 64'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_data", out_data, 64'h55AA);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset during WAIT_RSP; the late response must be ignored.
        send(2'd1, 3'd3, 64'h8000_0010, 64'h0);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'h9999_9999_9999_9999;
        @(negedge clk);
        chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mrst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("orphan_ignored", {63'd0, out_valid}, 64'd0);
        push(64'h77, 1'b0);
        send(2'd0, 3'd0, 64'h77, 64'h0);
        drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
